// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer: stage indices, register
// address width, the x0 constant and the source/destination match helper.
package pipe_ctl_pkg;

    localparam int unsigned RegAddrBusW = 5;
    localparam int unsigned NumStages   = 5;

    localparam logic [RegAddrBusW-1:0] X0 = '0;

    // Stage index into the per-stage valid/over vectors.
    typedef enum logic [2:0] {
        StageIf  = 3'd0,
        StageId  = 3'd1,
        StageExe = 3'd2,
        StageMem = 3'd3,
        StageWb  = 3'd4
    } stage_e;

    // True when a live destination register is read by the ID instruction; x0 never matches.
    function automatic logic src_match(
        input logic [RegAddrBusW-1:0] rs1,
        input logic [RegAddrBusW-1:0] rs2,
        input logic                   use1,
        input logic                   use2,
        input logic [RegAddrBusW-1:0] dest
    );
        return (dest != X0) && ((use1 && (rs1 == dest)) || (use2 && (rs2 == dest)));
    endfunction

endpackage

// File: rtl/pipe_ctl_hazard_unit.sv
// Read-after-write hazard detection for the ID stage. Purely combinational; the caller
// qualifies the result with the ID valid bit.
module hazard_unit
    import pipe_ctl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [RegAddrBusW-1:0] id_rs1_i,
    input  logic [RegAddrBusW-1:0] id_rs2_i,
    input  logic                   id_rs1_use_i,
    input  logic                   id_rs2_use_i,
    input  logic [RegAddrBusW-1:0] exe_dest_i,
    input  logic [RegAddrBusW-1:0] mem_dest_i,
    input  logic [RegAddrBusW-1:0] wb_dest_i,
    input  logic                   exe_is_load_i,
    output logic                   hazard_o
);

    logic exe_match;
    logic mem_match;
    logic wb_match;

    // With forwarding only a load in EXE cannot be bypassed; without it any pending write stalls.
    always_comb begin
        exe_match = src_match(id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i, exe_dest_i);
        mem_match = src_match(id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i, mem_dest_i);
        wb_match  = src_match(id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i, wb_dest_i);
        if (FWD_EN) begin
            hazard_o = exe_match & exe_is_load_i;
        end else begin
            hazard_o = exe_match | mem_match | wb_match;
        end
    end

endmodule

// File: rtl/pipe_ctl.sv
// Central pipeline sequencer: owns the stage valid bits, derives the allow-in chain from
// WB backwards, stalls ID on hazards, flushes IF on taken branches and counts retirements.
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_over_i,
    input  logic                   id_ready_i,
    input  logic                   exe_over_i,
    input  logic                   mem_over_i,
    input  logic                   wb_over_i,
    input  logic [RegAddrBusW-1:0] id_rs1_i,
    input  logic [RegAddrBusW-1:0] id_rs2_i,
    input  logic                   id_rs1_use_i,
    input  logic                   id_rs2_use_i,
    input  logic [RegAddrBusW-1:0] exe_dest_i,
    input  logic [RegAddrBusW-1:0] mem_dest_i,
    input  logic [RegAddrBusW-1:0] wb_dest_i,
    input  logic                   exe_is_load_i,
    input  logic                   br_taken_i,
    output logic                   if_valid_o,
    output logic                   id_valid_o,
    output logic                   exe_valid_o,
    output logic                   mem_valid_o,
    output logic                   wb_valid_o,
    output logic                   id_over_o,
    output logic                   if_allowin_o,
    output logic                   id_allowin_o,
    output logic                   exe_allowin_o,
    output logic                   mem_allowin_o,
    output logic                   wb_allowin_o,
    output logic                   if_flush_o,
    output logic [RETIRE_W-1:0]    retire_cnt_o
);

    logic [NumStages-1:0] valid_q;
    logic [NumStages-1:0] valid_d;
    logic [NumStages-1:0] over;
    logic [RETIRE_W-1:0]  retire_cnt_q;
    logic [RETIRE_W-1:0]  retire_cnt_d;

    logic hazard_raw;
    logic hazard;
    logic id_over;
    logic flush;
    logic if_allowin;
    logic id_allowin;
    logic exe_allowin;
    logic mem_allowin;
    logic wb_allowin;

    hazard_unit #(
        .FWD_EN (FWD_EN)
    ) u_hazard (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_use_i  (id_rs1_use_i),
        .id_rs2_use_i  (id_rs2_use_i),
        .exe_dest_i    (exe_dest_i),
        .mem_dest_i    (mem_dest_i),
        .wb_dest_i     (wb_dest_i),
        .exe_is_load_i (exe_is_load_i),
        .hazard_o      (hazard_raw)
    );

    // Per-stage completion terms; ID completion is decode-ready gated by the hazard check.
    always_comb begin
        hazard          = valid_q[StageId] & hazard_raw;
        id_over         = id_ready_i & ~hazard;
        over            = '0;
        over[StageIf]   = valid_q[StageIf]  & if_over_i;
        over[StageId]   = valid_q[StageId]  & id_over;
        over[StageExe]  = valid_q[StageExe] & exe_over_i;
        over[StageMem]  = valid_q[StageMem] & mem_over_i;
        over[StageWb]   = valid_q[StageWb]  & wb_over_i;
        // A flush only takes effect on an edge where ID actually moves on.
        flush           = br_taken_i & over[StageId];
    end

    // Allow-in chain: a stage accepts when empty or when it drains into an accepting successor.
    always_comb begin
        wb_allowin  = ~valid_q[StageWb]  | wb_over_i;
        mem_allowin = ~valid_q[StageMem] | (over[StageMem] & wb_allowin);
        exe_allowin = ~valid_q[StageExe] | (over[StageExe] & mem_allowin);
        id_allowin  = ~valid_q[StageId]  | (over[StageId]  & exe_allowin);
        if_allowin  = ~valid_q[StageIf]  | (over[StageIf]  & id_allowin);
    end

    // Next-state valid bits and retire count; stages that cannot accept hold their state.
    always_comb begin
        valid_d = valid_q;
        if (if_allowin) begin
            valid_d[StageIf] = 1'b1;
        end
        if (id_allowin) begin
            valid_d[StageId] = over[StageIf] & ~flush;
        end
        if (exe_allowin) begin
            valid_d[StageExe] = over[StageId];
        end
        if (mem_allowin) begin
            valid_d[StageMem] = over[StageExe];
        end
        if (wb_allowin) begin
            valid_d[StageWb] = over[StageMem];
        end
        retire_cnt_d = retire_cnt_q;
        if (over[StageWb]) begin
            retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
        end
    end

    // State registers; reset kills every in-flight instruction in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        if_valid_o    = valid_q[StageIf];
        id_valid_o    = valid_q[StageId];
        exe_valid_o   = valid_q[StageExe];
        mem_valid_o   = valid_q[StageMem];
        wb_valid_o    = valid_q[StageWb];
        id_over_o     = id_over;
        if_allowin_o  = if_allowin;
        id_allowin_o  = id_allowin;
        exe_allowin_o = exe_allowin;
        mem_allowin_o = mem_allowin;
        wb_allowin_o  = wb_allowin;
        if_flush_o    = flush;
        retire_cnt_o  = retire_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl. Two instances share stimulus: u_dut (forwarding) and
// u_dut_nf (no forwarding). Instruction tags are carried in bench-side bus registers
// loaded by u_dut's allow-in outputs; fetched tags are queued and checked in order at WB.
module tb_pipe_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_over_i, id_ready_i, exe_over_i, mem_over_i, wb_over_i;
    logic [4:0] id_rs1_i, id_rs2_i, exe_dest_i, mem_dest_i, wb_dest_i;
    logic       id_rs1_use_i, id_rs2_use_i, exe_is_load_i, br_taken_i;

    logic       if_valid_o, id_valid_o, exe_valid_o, mem_valid_o, wb_valid_o, id_over_o;
    logic       if_allowin_o, id_allowin_o, exe_allowin_o, mem_allowin_o, wb_allowin_o;
    logic       if_flush_o;
    logic [3:0] retire_cnt_o;

    logic       nf_if_valid, nf_id_valid, nf_exe_valid, nf_mem_valid, nf_wb_valid, nf_id_over;
    logic       nf_if_allowin, nf_id_allowin, nf_exe_allowin, nf_mem_allowin, nf_wb_allowin;
    logic       nf_if_flush;
    logic [3:0] nf_retire_cnt;

    int checks = 0;
    int errors = 0;

    int sb_q[$];
    int next_tag = 0;
    int if_tag = -1, id_tag = -1, exe_tag = -1, mem_tag = -1, wb_tag = -1;

    always #5 clk = ~clk;

    pipe_ctl #(.FWD_EN(1'b1), .RETIRE_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_over_i(if_over_i), .id_ready_i(id_ready_i), .exe_over_i(exe_over_i),
        .mem_over_i(mem_over_i), .wb_over_i(wb_over_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
        .exe_dest_i(exe_dest_i), .mem_dest_i(mem_dest_i), .wb_dest_i(wb_dest_i),
        .exe_is_load_i(exe_is_load_i), .br_taken_i(br_taken_i),
        .if_valid_o(if_valid_o), .id_valid_o(id_valid_o), .exe_valid_o(exe_valid_o),
        .mem_valid_o(mem_valid_o), .wb_valid_o(wb_valid_o), .id_over_o(id_over_o),
        .if_allowin_o(if_allowin_o), .id_allowin_o(id_allowin_o),
        .exe_allowin_o(exe_allowin_o), .mem_allowin_o(mem_allowin_o),
        .wb_allowin_o(wb_allowin_o), .if_flush_o(if_flush_o), .retire_cnt_o(retire_cnt_o)
    );

    pipe_ctl #(.FWD_EN(1'b0), .RETIRE_W(4)) u_dut_nf (
        .clk(clk), .rst(rst),
        .if_over_i(if_over_i), .id_ready_i(id_ready_i), .exe_over_i(exe_over_i),
        .mem_over_i(mem_over_i), .wb_over_i(wb_over_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
        .exe_dest_i(exe_dest_i), .mem_dest_i(mem_dest_i), .wb_dest_i(wb_dest_i),
        .exe_is_load_i(exe_is_load_i), .br_taken_i(br_taken_i),
        .if_valid_o(nf_if_valid), .id_valid_o(nf_id_valid), .exe_valid_o(nf_exe_valid),
        .mem_valid_o(nf_mem_valid), .wb_valid_o(nf_wb_valid), .id_over_o(nf_id_over),
        .if_allowin_o(nf_if_allowin), .id_allowin_o(nf_id_allowin),
        .exe_allowin_o(nf_exe_allowin), .mem_allowin_o(nf_mem_allowin),
        .wb_allowin_o(nf_wb_allowin), .if_flush_o(nf_if_flush), .retire_cnt_o(nf_retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bench-side bus registers and in-order retirement scoreboard for u_dut.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            next_tag <= 0;
        end else begin
            if (wb_valid_o && wb_over_i) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("retire_tag", wb_tag, sb_q.pop_front());
            end
            if (wb_allowin_o)  wb_tag  <= mem_tag;
            if (mem_allowin_o) mem_tag <= exe_tag;
            if (exe_allowin_o) exe_tag <= id_tag;
            if (id_allowin_o)  id_tag  <= if_tag;
            if (if_allowin_o) begin
                if_tag <= next_tag;
                sb_q.push_back(next_tag);
                next_tag <= next_tag + 1;
            end
        end
    end

    initial begin
        int squash;
        int found;
        logic [3:0] c0;
        rst = 1'b1;
        if_over_i = 1'b1; id_ready_i = 1'b1; exe_over_i = 1'b1;
        mem_over_i = 1'b1; wb_over_i = 1'b1;
        id_rs1_i = '0; id_rs2_i = '0; id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
        exe_dest_i = '0; mem_dest_i = '0; wb_dest_i = '0;
        exe_is_load_i = 1'b0; br_taken_i = 1'b0;

        // Reset and fill latency.
        repeat (3) step();
        check("rst_valids", {if_valid_o, id_valid_o, exe_valid_o, mem_valid_o, wb_valid_o}, 0);
        check("rst_retire", retire_cnt_o, 0);
        rst = 1'b0;
        step();
        check("c1_if_valid", if_valid_o, 1);
        check("c1_id_valid", id_valid_o, 0);
        repeat (3) step();
        check("c4_wb_valid", wb_valid_o, 0);
        step();
        check("c5_wb_valid", wb_valid_o, 1);
        check("c5_retire", retire_cnt_o, 0);
        step();
        check("c6_retire", retire_cnt_o, 1);
        step();
        check("c7_retire", retire_cnt_o, 2);
        repeat (13) step();
        check("c20_retire", retire_cnt_o, 15);
        step();
        check("c21_retire_wrap", retire_cnt_o, 0);

        // Load-use stall with forwarding.
        exe_dest_i = 5'd5; exe_is_load_i = 1'b1; id_rs1_i = 5'd5; id_rs1_use_i = 1'b1;
        #1;
        check("lu_id_over", id_over_o, 0);
        check("lu_id_allowin", id_allowin_o, 0);
        check("lu_if_allowin", if_allowin_o, 0);
        br_taken_i = 1'b1;
        #1;
        check("stall_br_no_flush", if_flush_o, 0);
        br_taken_i = 1'b0;
        step();
        check("lu_bubble", exe_valid_o, 0);
        check("lu_id_held", id_valid_o, 1);
        exe_dest_i = '0; exe_is_load_i = 1'b0;
        #1;
        check("lu_id_go", id_over_o, 1);
        step();
        check("lu_exe_refill", exe_valid_o, 1);

        // Non-load EXE match: forwarding covers it, no-forward instance stalls.
        exe_dest_i = 5'd5;
        #1;
        check("fwd_alu_no_stall", id_over_o, 1);
        check("nf_alu_stall", nf_id_over, 0);
        exe_dest_i = '0; id_rs1_use_i = 1'b0; id_rs1_i = '0;

        // No forwarding: MEM then WB dest match stalls until both clear.
        mem_dest_i = 5'd7; id_rs2_i = 5'd7; id_rs2_use_i = 1'b1;
        #1;
        check("nf_mem_stall", nf_id_over, 0);
        check("fwd_mem_no_stall", id_over_o, 1);
        step();
        mem_dest_i = '0; wb_dest_i = 5'd7;
        #1;
        check("nf_wb_stall", nf_id_over, 0);
        step();
        wb_dest_i = '0;
        #1;
        check("nf_clear", nf_id_over, 1);
        id_rs2_i = '0; id_rs1_i = '0; id_rs1_use_i = 1'b1;
        #1;
        check("nf_x0_no_stall", nf_id_over, 1);
        id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
        repeat (6) step();

        // Taken branch with ID advancing flushes the instruction in IF.
        br_taken_i = 1'b1;
        squash = if_tag;
        #1;
        check("br_flush", if_flush_o, 1);
        step();
        br_taken_i = 1'b0;
        check("br_id_bubble", id_valid_o, 0);
        check("br_if_refetch", if_valid_o, 1);
        found = 0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (found == 0 && sb_q[i] == squash) begin
                sb_q.delete(i);
                found = 1;
            end
        end
        check("br_squash_queued", found, 1);
        repeat (8) step();

        // MEM wait for 3 cycles in steady flow.
        c0 = retire_cnt_o;
        mem_over_i = 1'b0;
        #1;
        check("mw_allowin", {if_allowin_o, id_allowin_o, exe_allowin_o, mem_allowin_o}, 0);
        check("mw_wb_allowin", wb_allowin_o, 1);
        step();
        check("mw_wb_drop1", wb_valid_o, 0);
        step();
        step();
        check("mw_wb_drop3", wb_valid_o, 0);
        check("mw_valids_held", {if_valid_o, id_valid_o, exe_valid_o, mem_valid_o}, 4'hf);
        check("mw_retire", retire_cnt_o, 32'(c0 + 4'd1));
        mem_over_i = 1'b1;
        step();
        check("mw_wb_back", wb_valid_o, 1);
        repeat (6) step();

        // Reset mid-flow.
        check("pre_rst_full", {if_valid_o, id_valid_o, exe_valid_o, mem_valid_o}, 4'hf);
        rst = 1'b1;
        step();
        check("mid_rst_valids", {if_valid_o, id_valid_o, exe_valid_o, mem_valid_o, wb_valid_o}, 0);
        check("mid_rst_retire", retire_cnt_o, 0);
        check("mid_rst_nf_valids",
              {nf_if_valid, nf_id_valid, nf_exe_valid, nf_mem_valid, nf_wb_valid}, 0);
        rst = 1'b0;
        step();
        check("post_rst_if", if_valid_o, 1);
        repeat (10) step();
        check("post_rst_retire", retire_cnt_o, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
